// File: rtl/ex_stage_if.sv
// Decode-to-execute bus for ex_stage: the decoded instruction going in, and the
// registered result, op flags and upstream stall coming out.
interface ex_stage_if;
    logic        valid_in;
    logic [3:0]  opcode;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [3:0]  imm;
    logic [3:0]  rd_in;
    logic        write_reg_in;
    logic        flush;

    logic [31:0] alu_result;
    logic [3:0]  rd_out;
    logic        write_reg_out;
    logic        valid_out;
    logic        beq_out;
    logic        bne_out;
    logic        ld_out;
    logic        st_out;
    logic        fft_out;
    logic [3:0]  imm_addr_out;
    logic [3:0]  branch_target_out;
    logic        stall;

    modport master (
        output valid_in, opcode, rs1_val, rs2_val, imm, rd_in, write_reg_in, flush,
        input  alu_result, rd_out, write_reg_out, valid_out, beq_out, bne_out,
               ld_out, st_out, fft_out, imm_addr_out, branch_target_out, stall
    );

    modport slave (
        input  valid_in, opcode, rs1_val, rs2_val, imm, rd_in, write_reg_in, flush,
        output alu_result, rd_out, write_reg_out, valid_out, beq_out, bne_out,
               ld_out, st_out, fft_out, imm_addr_out, branch_target_out, stall
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/branch/memory ops registered to the memory stage.
// Define EX_MUL_EN to add a 32-cycle shift-add multiplier that stalls upstream while busy.
module ex_stage (
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_BNE = 4'd9;
    localparam logic [3:0] OP_LD  = 4'd10;
    localparam logic [3:0] OP_ST  = 4'd11;
    localparam logic [3:0] OP_FFT = 4'd12;

    // One-hot op flags, ordered {beq, bne, ld, st, fft}.
    localparam logic [4:0] FLAG_BEQ = 5'b10000;
    localparam logic [4:0] FLAG_BNE = 5'b01000;
    localparam logic [4:0] FLAG_LD  = 5'b00100;
    localparam logic [4:0] FLAG_ST  = 5'b00010;
    localparam logic [4:0] FLAG_FFT = 5'b00001;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        wr;
        logic        valid;
        logic [4:0]  flags;
        logic [3:0]  imm;
    } out_t;

    out_t q, d, dec;

`ifdef EX_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'd7;
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    // Multiplicand shifts left and multiplier shifts right each iteration.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic [3:0]  rd;
        logic        wr;
        logic [3:0]  imm;
    } mul_t;

    logic [0:0]  state, state_d;
    logic [4:0]  cnt, cnt_d;
    mul_t        mul, mul_d;
    logic [31:0] partial;
`endif

    always_comb begin
        // NOTE: every field gets a default before the case, so no path can infer a latch.
        dec       = '0;
        dec.valid = 1'b1;
        dec.rd    = bus.rd_in;
        dec.imm   = bus.imm;
        case (bus.opcode)
            OP_ADD: begin dec.result = bus.rs1_val + bus.rs2_val;          dec.wr = bus.write_reg_in; end
            OP_SUB: begin dec.result = bus.rs1_val - bus.rs2_val;          dec.wr = bus.write_reg_in; end
            OP_AND: begin dec.result = bus.rs1_val & bus.rs2_val;          dec.wr = bus.write_reg_in; end
            OP_OR:  begin dec.result = bus.rs1_val | bus.rs2_val;          dec.wr = bus.write_reg_in; end
            OP_XOR: begin dec.result = bus.rs1_val ^ bus.rs2_val;          dec.wr = bus.write_reg_in; end
            OP_SLL: begin dec.result = bus.rs1_val << bus.rs2_val[4:0];    dec.wr = bus.write_reg_in; end
            OP_SRL: begin dec.result = bus.rs1_val >> bus.rs2_val[4:0];    dec.wr = bus.write_reg_in; end
            OP_BEQ: begin dec.result = {31'd0, bus.rs1_val == bus.rs2_val}; dec.flags = FLAG_BEQ; end
            OP_BNE: begin dec.result = {31'd0, bus.rs1_val != bus.rs2_val}; dec.flags = FLAG_BNE; end
            OP_LD:  begin dec.result = bus.rs1_val; dec.wr = bus.write_reg_in; dec.flags = FLAG_LD; end
            OP_ST:  begin dec.result = bus.rs2_val; dec.flags = FLAG_ST; end
            OP_FFT: begin dec.result = bus.rs1_val; dec.flags = FLAG_FFT; end
            default: ;  // NOP, and MUL when it reaches this decoder
        endcase
    end

    always_comb begin
        // Bubble by default: result, rd and imm copies hold their last values.
        d       = q;
        d.valid = 1'b0;
        d.wr    = 1'b0;
        d.flags = '0;
`ifdef EX_MUL_EN
        state_d = state;
        cnt_d   = cnt;
        mul_d   = mul;
        partial = mul.b[0] ? mul.a : 32'd0;
`endif
        if (bus.flush) begin
`ifdef EX_MUL_EN
            state_d = IDLE;
            cnt_d   = '0;
`endif
        end
`ifdef EX_MUL_EN
        else if (state == MUL_BUSY) begin
            mul_d.acc = mul.acc + partial;
            mul_d.a   = mul.a << 1;
            mul_d.b   = mul.b >> 1;
            cnt_d     = cnt + 5'd1;
            if (cnt == 5'd31) begin
                d.result = mul.acc + partial;
                d.rd     = mul.rd;
                d.wr     = mul.wr;
                d.imm    = mul.imm;
                d.valid  = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
            end
        end else if (bus.valid_in && bus.opcode == OP_MUL) begin
            mul_d.a   = bus.rs1_val;
            mul_d.b   = bus.rs2_val;
            mul_d.acc = '0;
            mul_d.rd  = bus.rd_in;
            mul_d.wr  = bus.write_reg_in;
            mul_d.imm = bus.imm;
            state_d   = MUL_BUSY;
            cnt_d     = '0;
        end
`endif
        else if (bus.valid_in) begin
            d = dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            q <= '0;
`ifdef EX_MUL_EN
            state <= IDLE;
            cnt   <= '0;
            mul   <= '0;
`endif
        end else begin
            q <= d;
`ifdef EX_MUL_EN
            state <= state_d;
            cnt   <= cnt_d;
            mul   <= mul_d;
`endif
        end
    end

    assign bus.alu_result        = q.result;
    assign bus.rd_out            = q.rd;
    assign bus.write_reg_out     = q.wr;
    assign bus.valid_out         = q.valid;
    assign bus.beq_out           = q.flags[4];
    assign bus.bne_out           = q.flags[3];
    assign bus.ld_out            = q.flags[2];
    assign bus.st_out            = q.flags[1];
    assign bus.fft_out           = q.flags[0];
    assign bus.imm_addr_out      = q.imm;
    assign bus.branch_target_out = q.imm;

`ifdef EX_MUL_EN
    assign bus.stall = (state == MUL_BUSY);
`else
    assign bus.stall = 1'b0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a stimulus process runs an opcode-level reference
// model and queues expectations; a monitor pops and compares each clock.
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        wr;
        logic [4:0]  flags;  // {beq, bne, ld, st, fft}
        logic [3:0]  imm;
    } txn_t;

    typedef struct packed {
        logic stall;
        logic valid;
    } edge_t;

    txn_t        txn_q[$];
    edge_t       edge_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    logic [31:0] held = '0;
    int          busy_left = 0;
    txn_t        mul_txn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] im, input logic [3:0] rd, input logic w);
        txn_t t;
        t = '{result: 32'd0, rd: rd, wr: 1'b0, flags: 5'd0, imm: im};
        case (op)
            4'd0:  begin t.result = a + b; t.wr = w; end
            4'd1:  begin t.result = a - b; t.wr = w; end
            4'd2:  begin t.result = a & b; t.wr = w; end
            4'd3:  begin t.result = a | b; t.wr = w; end
            4'd4:  begin t.result = a ^ b; t.wr = w; end
            4'd5:  begin t.result = a << (b % 32); t.wr = w; end
            4'd6:  begin t.result = a >> (b % 32); t.wr = w; end
            4'd8:  begin t.result = (a == b) ? 32'd1 : 32'd0; t.flags = 5'b10000; end
            4'd9:  begin t.result = (a != b) ? 32'd1 : 32'd0; t.flags = 5'b01000; end
            4'd10: begin t.result = a; t.wr = w; t.flags = 5'b00100; end
            4'd11: begin t.result = b; t.flags = 5'b00010; end
            4'd12: begin t.result = a; t.flags = 5'b00001; end
            default: ;
        endcase
        return t;
    endfunction

    // Drive one instruction for the next rising edge and record what that edge must produce.
    task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] im, input logic [3:0] rd, input logic w, input logic fl);
        logic exp_valid;
        @(negedge clk);
        bus.valid_in     = v;
        bus.opcode       = op;
        bus.rs1_val      = a;
        bus.rs2_val      = b;
        bus.imm          = im;
        bus.rd_in        = rd;
        bus.write_reg_in = w;
        bus.flush        = fl;
        exp_valid = 1'b0;
        if (fl) begin
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                txn_q.push_back(mul_txn);
                exp_valid = 1'b1;
            end
        end
`ifdef EX_MUL_EN
        else if (v && op == 4'd7) begin
            busy_left = 32;
            mul_txn   = '{result: a * b, rd: rd, wr: w, flags: 5'd0, imm: im};
        end
`endif
        else if (v) begin
            txn_q.push_back(model(op, a, b, im, rd, w));
            exp_valid = 1'b1;
        end
        edge_q.push_back('{stall: (busy_left > 0), valid: exp_valid});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_result"}, bus.alu_result, 0);
        check({tag, "_rd_out"}, bus.rd_out, 0);
        check({tag, "_write_reg_out"}, bus.write_reg_out, 0);
        check({tag, "_valid_out"}, bus.valid_out, 0);
        check({tag, "_flags"}, {bus.beq_out, bus.bne_out, bus.ld_out, bus.st_out, bus.fft_out}, 0);
        check({tag, "_imm_addr_out"}, bus.imm_addr_out, 0);
        check({tag, "_branch_target_out"}, bus.branch_target_out, 0);
        check({tag, "_stall"}, bus.stall, 0);
    endtask

    task automatic set_idle_inputs();
        bus.valid_in = 1'b0; bus.opcode = '0; bus.rs1_val = '0; bus.rs2_val = '0;
        bus.imm = '0; bus.rd_in = '0; bus.write_reg_in = 1'b0; bus.flush = 1'b0;
    endtask

    // Pulse reset between edges and check that outputs clear without waiting for a clock.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_zero("async_reset");
        txn_q.delete();
        edge_q.delete();
        busy_left = 0;
        held      = '0;
        @(negedge clk);
        set_idle_inputs();
        reset = 1'b0;
        edge_q.push_back('{stall: 1'b0, valid: 1'b0});
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        edge_t e;
        txn_t  t;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && edge_q.size() > 0) begin
                e = edge_q.pop_front();
                check("stall", bus.stall, e.stall);
                check("valid_out", bus.valid_out, e.valid);
                if (bus.valid_out) begin
                    if (txn_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got result 0x%0h, expected no output (t=%0t)",
                                 bus.alu_result, $time);
                    end else begin
                        t = txn_q.pop_front();
                        check("alu_result", bus.alu_result, t.result);
                        check("rd_out", bus.rd_out, t.rd);
                        check("write_reg_out", bus.write_reg_out, t.wr);
                        check("flags", {bus.beq_out, bus.bne_out, bus.ld_out, bus.st_out, bus.fft_out}, t.flags);
                        check("imm_addr_out", bus.imm_addr_out, t.imm);
                        check("branch_target_out", bus.branch_target_out, t.imm);
                        held = t.result;
                    end
                end else begin
                    check("bubble_write_reg", bus.write_reg_out, 0);
                    check("bubble_flags", {bus.beq_out, bus.bne_out, bus.ld_out, bus.st_out, bus.fft_out}, 0);
                    check("bubble_hold", bus.alu_result, held);
                end
            end
        end
    end

    initial begin : stimulus
        logic        v, w, fl;
        logic [3:0]  op, im, rd;
        logic [31:0] a, b;
        reset = 1'b1;
        set_idle_inputs();
        @(negedge clk);
        check_zero("power_on_reset");
        reset = 1'b0;
        edge_q.push_back('{stall: 1'b0, valid: 1'b0});
        mon_en = 1'b1;

        // Directed: wrap-around add, branch compares, MUL opcode, flush over a valid op.
        issue(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd2, 4'd0, 4'd3, 1'b1, 1'b0);
        issue(1'b1, 4'd8, 32'h55, 32'h55, 4'd9, 4'd1, 1'b1, 1'b0);
        issue(1'b1, 4'd9, 32'h55, 32'h55, 4'd9, 4'd1, 1'b1, 1'b0);
        issue(1'b1, 4'd7, 32'd3, 32'd4, 4'd2, 4'd5, 1'b1, 1'b0);
        idle(1);
        issue(1'b1, 4'd0, 32'd10, 32'd20, 4'd1, 4'd6, 1'b1, 1'b1);
        issue(1'b1, 4'd5, 32'h8000_0001, 32'hFFFF_FFFF, 4'd4, 4'd7, 1'b1, 1'b0);
        issue(1'b1, 4'd6, 32'h8000_0001, 32'h0000_0020, 4'd4, 4'd7, 1'b1, 1'b0);
        for (int o = 0; o < 16; o++)
            issue(1'b1, 4'(o), $urandom, $urandom, 4'(o), 4'(15 - o), 1'b1, 1'b0);

`ifdef EX_MUL_EN
        issue(1'b1, 4'd7, 32'h0001_0000, 32'h0003_0001, 4'd3, 4'd8, 1'b1, 1'b0);
        idle(33);
        issue(1'b1, 4'd7, 32'd1234, 32'd5678, 4'd3, 4'd8, 1'b1, 1'b0);
        idle(10);
        issue(1'b1, 4'd0, 32'd1, 32'd1, 4'd0, 4'd2, 1'b1, 1'b1);
        idle(40);
        issue(1'b1, 4'd7, 32'd77, 32'd99, 4'd3, 4'd8, 1'b1, 1'b0);
        idle(5);
`else
        issue(1'b1, 4'd0, 32'd5, 32'd6, 4'd3, 4'd8, 1'b1, 1'b0);
`endif
        mid_reset();
        issue(1'b1, 4'd1, 32'd7, 32'd9, 4'd0, 4'd4, 1'b1, 1'b0);
        idle(40);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im = 4'($urandom);
            rd = 4'($urandom);
            w  = 1'($urandom);
            v  = ($urandom_range(0, 4) != 0);
            fl = ($urandom_range(0, 9) == 0);
            issue(v, op, a, b, im, rd, w, fl);
        end

        idle(40);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        check("txn_q_drained", txn_q.size(), 0);
        check("edge_q_drained", edge_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
